// File: rtl/ofdm_frame_generator.sv
// OFDM burst framer: preamble, FCH header symbol, then N data symbols with cyclic prefix from a 64-entry buffer.
// Latency: output samples are registered, visible one cycle after the stepping cycle; input writes land same cycle.
// Backpressure: output stalls while i_wayt_read_data=0; input accepted only while flag_ready_read=1, en=0 freezes all.
module ofdm_frame_generator #(
    parameter int MEMORY_SYZE = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          beginTX,
    input  logic                          valid,
    input  logic signed [15:0]            i_mod_data_i,
    input  logic signed [15:0]            i_mod_data_q,
    input  logic [MEMORY_SYZE-1:0]        data_frame_size,
    input  logic [2:0]                    modulation,
    input  logic                          i_wayt_read_data,
    output logic                          flag_ready_read,
    output logic signed [15:0]            out_data_i,
    output logic signed [15:0]            out_data_q,
    output logic                          tx_valid,
    output logic                          done_transmit,
    output logic [3:0]                    o_state_OFDM,
    output logic [MEMORY_SYZE-1:0]        d_data_symbols_counter,
    output logic [MEMORY_SYZE-1:0]        d_counter_sample,
    output logic signed [15:0]            d_in_fft_data_i,
    output logic signed [15:0]            d_in_fft_data_q,
    output logic                          d_fft_valid
);
    localparam int N_SYM = 64;
    localparam int N_CP  = 16;
    localparam int N_PRE = 160;
    localparam logic signed [15:0] AMP     = 16'sd4096;
    localparam logic signed [15:0] NEG_AMP = -16'sd4096;
    localparam logic [MEMORY_SYZE-1:0] PRE_LAST  = MEMORY_SYZE'(N_PRE - 1);
    localparam logic [MEMORY_SYZE-1:0] FCH_LAST  = MEMORY_SYZE'(N_CP + N_SYM - 1);
    localparam logic [MEMORY_SYZE-1:0] SYM_LAST  = MEMORY_SYZE'(N_SYM - 1);
    localparam logic [MEMORY_SYZE-1:0] CP_LAST   = MEMORY_SYZE'(N_CP - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_PRE  = 4'd1,
        S_FCH  = 4'd2,
        S_LOAD = 4'd3,
        S_CP   = 4'd4,
        S_BODY = 4'd5,
        S_DONE = 4'd6
    } state_t;

    state_t                   r_state;
    logic [MEMORY_SYZE-1:0]   r_cnt;
    logic [MEMORY_SYZE-1:0]   r_sym_cnt;
    logic [MEMORY_SYZE-1:0]   r_size;
    logic [2:0]               r_mod;
    logic [31:0]              r_buf [0:N_SYM-1];
    logic signed [15:0]       r_out_i;
    logic signed [15:0]       r_out_q;
    logic                     r_tx_valid;
    logic                     r_done;

    logic                     w_emit_state;
    logic                     w_step;
    logic                     w_wr;
    logic [15:0]              w_hdr;
    logic [5:0]               w_rd_addr;
    logic [31:0]              w_rd;
    logic signed [15:0]       w_smp_i;
    logic signed [15:0]       w_smp_q;
    logic [MEMORY_SYZE-1:0]   w_sym_next;

    assign w_emit_state = (r_state == S_PRE) || (r_state == S_FCH) ||
                          (r_state == S_CP)  || (r_state == S_BODY);
    assign w_step     = en && i_wayt_read_data && w_emit_state;
    assign w_wr       = en && valid && (r_state == S_LOAD);
    assign w_hdr      = {r_mod, r_size[12:0]};
    assign w_rd_addr  = (r_state == S_CP) ? (6'd48 + r_cnt[5:0]) : r_cnt[5:0];
    assign w_rd       = r_buf[w_rd_addr];
    assign w_sym_next = r_sym_cnt + 1'b1;

    // FCH index j is 48..63 then 0..63; both map to header bit r_cnt mod 16.
    always_comb begin
        w_smp_i = '0;
        w_smp_q = '0;
        case (r_state)
            S_PRE:        w_smp_i = r_cnt[3] ? NEG_AMP : AMP;
            S_FCH:        w_smp_i = w_hdr[r_cnt[3:0]] ? AMP : NEG_AMP;
            S_CP, S_BODY: begin
                w_smp_i = w_rd[31:16];
                w_smp_q = w_rd[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_cnt[5:0]] <= {i_mod_data_i, i_mod_data_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sym_cnt  <= '0;
            r_size     <= '0;
            r_mod      <= '0;
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else if (en) begin
            r_tx_valid <= 1'b0;
            if (w_step) begin
                r_out_i    <= w_smp_i;
                r_out_q    <= w_smp_q;
                r_tx_valid <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (beginTX) begin
                        r_size    <= data_frame_size;
                        r_mod     <= modulation;
                        r_cnt     <= '0;
                        r_sym_cnt <= '0;
                        r_done    <= 1'b0;
                        r_state   <= S_PRE;
                    end
                end
                S_PRE: if (i_wayt_read_data) begin
                    if (r_cnt == PRE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FCH: if (i_wayt_read_data) begin
                    if (r_cnt == FCH_LAST) begin
                        r_cnt <= '0;
                        if (r_size != '0) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: if (valid) begin
                    if (r_cnt == SYM_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_CP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CP: if (i_wayt_read_data) begin
                    if (r_cnt == CP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_BODY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BODY: if (i_wayt_read_data) begin
                    if (r_cnt == SYM_LAST) begin
                        r_cnt     <= '0;
                        r_sym_cnt <= w_sym_next;
                        if (w_sym_next == r_size) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end else begin
            r_tx_valid <= 1'b0;
        end
    end

    assign flag_ready_read        = (r_state == S_LOAD);
    assign out_data_i             = r_out_i;
    assign out_data_q             = r_out_q;
    assign tx_valid               = r_tx_valid;
    assign done_transmit          = r_done;
    assign o_state_OFDM           = r_state;
    assign d_data_symbols_counter = r_sym_cnt;
    assign d_counter_sample       = r_cnt;
    assign d_fft_valid            = w_wr;
    assign d_in_fft_data_i        = w_wr ? i_mod_data_i : 16'sd0;
    assign d_in_fft_data_q        = w_wr ? i_mod_data_q : 16'sd0;
endmodule

// File: tb/tb_ofdm_frame_generator.sv
// Directed bench for ofdm_frame_generator: expected burst samples are queued at burst start and popped per tx_valid.
module tb_ofdm_frame_generator;
    localparam logic [15:0] AMP = 16'h1000;
    localparam logic [15:0] NEG = 16'hF000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        beginTX = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] mdi = '0;
    logic [15:0] mdq = '0;
    logic [15:0] dfs = '0;
    logic [2:0]  modn = '0;
    logic        rdy = 1'b1;

    logic        flag_ready_read;
    logic signed [15:0] out_i, out_q;
    logic        tx_valid, done_transmit;
    logic [3:0]  st;
    logic [15:0] symc, smpc;
    logic signed [15:0] fi, fq;
    logic        fv;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] sb[$];
    logic [15:0] cap_i [0:2047];
    int n_out = 0;
    int k = 0;
    logic will_consume = 1'b0;
    logic toggle = 1'b0;
    logic hold = 1'b0;
    logic prev_rdy = 1'b1;
    logic [31:0] e;

    ofdm_frame_generator #(.MEMORY_SYZE(16)) dut (
        .clk(clk), .reset(reset), .en(en), .beginTX(beginTX), .valid(valid),
        .i_mod_data_i(mdi), .i_mod_data_q(mdq), .data_frame_size(dfs), .modulation(modn),
        .i_wayt_read_data(rdy), .flag_ready_read(flag_ready_read),
        .out_data_i(out_i), .out_data_q(out_q), .tx_valid(tx_valid),
        .done_transmit(done_transmit), .o_state_OFDM(st),
        .d_data_symbols_counter(symc), .d_counter_sample(smpc),
        .d_in_fft_data_i(fi), .d_in_fft_data_q(fq), .d_fft_valid(fv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int n, input logic [2:0] m);
        logic [15:0] h;
        int j, v;
        h = {m, 13'(n)};
        for (int c = 0; c < 160; c++) sb.push_back({(c[3] ? NEG : AMP), 16'h0});
        for (int c = 0; c < 80; c++) begin
            j = (c < 16) ? c + 48 : c - 16;
            sb.push_back({(h[j % 16] ? AMP : NEG), 16'h0});
        end
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < 80; c++) begin
                v = 64 * s + ((c < 16) ? 48 + c : c - 16);
                sb.push_back({16'(v), 16'(-v)});
            end
        end
    endtask

    // Input feeder, ready driver and output scoreboard share one block so their ordering is fixed.
    always @(negedge clk) begin
        if (tx_valid) begin
            check("tx_on_ready", {31'd0, prev_rdy}, 32'd1);
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            check("sample", {out_i, out_q}, e);
            if (n_out < 2048) cap_i[n_out] = out_i;
            n_out++;
        end
        if (will_consume) k++;
        rdy = toggle ? ~rdy : 1'b1;
        prev_rdy = rdy;
        valid = !hold;
        mdi = 16'(k);
        mdq = 16'(-k);
        will_consume = valid && flag_ready_read && en && reset;
    end

    task automatic start_burst(input int n, input logic [2:0] m);
        @(negedge clk);
        push_model(n, m);
        n_out = 0;
        k = 0;
        will_consume = 1'b0;
        dfs = 16'(n);
        modn = m;
        beginTX = 1'b1;
        @(negedge clk);
        beginTX = 1'b0;
        dfs = 16'h0007;
        modn = 3'd1;
        check("start_state", {28'd0, st}, 32'd1);
        check("start_done_clr", {31'd0, done_transmit}, 32'd0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (st !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {28'd0, st}, {28'd0, s});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_transmit !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done_transmit}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_state", {28'd0, st}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_out", {out_i, out_q}, 32'd0);
        check("rst_done", {31'd0, done_transmit}, 32'd0);
        check("rst_flag", {31'd0, flag_ready_read}, 32'd0);
        check("rst_counters", {symc, smpc}, 32'd0);
        check("rst_fft", {fi, fq}, 32'd0);
        reset = 1'b1;
        en = 1'b1;
        @(negedge clk);

        // N=0: preamble + FCH only
        start_burst(0, 3'd4);
        wait_done(1000, "A_done");
        check("A_count", n_out, 240);
        check("A_s0", {16'd0, cap_i[0]}, {16'd0, AMP});
        check("A_s8", {16'd0, cap_i[8]}, {16'd0, NEG});
        check("A_state", {28'd0, st}, 32'd6);
        check("A_sb_left", sb.size(), 0);

        // N=10 ramp, restarted from DONE
        start_burst(10, 3'd4);
        wait_done(3000, "B_done");
        check("B_count", n_out, 1040);
        check("B_symcnt", {16'd0, symc}, 32'd10);
        check("B_fch_j0", {16'd0, cap_i[176]}, {16'd0, NEG});
        check("B_fch_j1", {16'd0, cap_i[177]}, {16'd0, AMP});
        check("B_fch_j15", {16'd0, cap_i[191]}, {16'd0, AMP});
        check("B_sym0_cp0", {16'd0, cap_i[240]}, 32'd48);
        check("B_sym0_body0", {16'd0, cap_i[256]}, 32'd0);
        check("B_state", {28'd0, st}, 32'd6);
        check("B_sb_left", sb.size(), 0);

        // Ready toggling every cycle, plus a 20-cycle valid gap mid-LOAD
        toggle = 1'b1;
        start_burst(10, 3'd4);
        wait_state(4'd3, 1000, "C_load");
        repeat (10) @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            check("C_gap_tx", {31'd0, tx_valid}, 32'd0);
            check("C_gap_state", {28'd0, st}, 32'd3);
        end
        hold = 1'b0;
        wait_done(8000, "C_done");
        check("C_count", n_out, 1040);
        check("C_sb_left", sb.size(), 0);
        toggle = 1'b0;

        // Reset mid-BODY aborts the burst
        start_burst(3, 3'd4);
        wait_state(4'd5, 3000, "D_body");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("D_rst_state", {28'd0, st}, 32'd0);
        check("D_rst_tx", {31'd0, tx_valid}, 32'd0);
        check("D_rst_out", {out_i, out_q}, 32'd0);
        check("D_rst_cnt", {symc, smpc}, 32'd0);
        check("D_rst_flags", {30'd0, done_transmit, flag_ready_read}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        start_burst(1, 3'd2);
        wait_done(2000, "E_done");
        check("E_count", n_out, 320);
        check("E_s0", {16'd0, cap_i[0]}, {16'd0, AMP});
        check("E_symcnt", {16'd0, symc}, 32'd1);
        check("E_sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ofdm_frame_generator.md
Name: ofdm_frame_generator

Overview:
- Builds one complete OFDM baseband burst from a stream of modulated (constellation-mapped) IQ samples.
- Burst order: fixed preamble, then a frame-control header (FCH) symbol, then data_frame_size data symbols, each with a cyclic prefix (CP).
- Sits between the upstream mapper (IQ source, valid handshake) and the downstream TX sample FIFO (tx_valid write strobe).
- Subcarrier-to-time mapping is external; this block does symbol buffering, CP insertion and framing.

Parameters:
- MEMORY_SYZE, 16: width of data_frame_size and of the symbol/sample counters.
- Fixed localparams: N_SYM=64 samples per symbol, N_CP=16, N_PRE=160, AMP=16'sd4096.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low all state, counters and outputs hold and tx_valid=0.
- beginTX  in  1  start pulse/level; sampled in IDLE or DONE only.
- valid  in  1  i_mod_data_i/q valid this cycle.
- i_mod_data_i  in  16  signed input sample I.
- i_mod_data_q  in  16  signed input sample Q.
- data_frame_size  in  MEMORY_SYZE  number of data symbols; latched at start.
- modulation  in  3  modulation code; latched at start, carried in FCH.
- i_wayt_read_data  in  1  downstream ready; output stalls when low.
- flag_ready_read  out  1  block accepts input samples this cycle.
- out_data_i  out  16  signed output sample I.
- out_data_q  out  16  signed output sample Q.
- tx_valid  out  1  out_data_i/q valid this cycle.
- done_transmit  out  1  burst complete (level).
- o_state_OFDM  out  4  current state code.
- d_data_symbols_counter  out  MEMORY_SYZE  data symbols fully emitted.
- d_counter_sample  out  MEMORY_SYZE  sample index within current section.
- d_in_fft_data_i  out  16  I of sample being written to the symbol buffer.
- d_in_fft_data_q  out  16  Q of sample being written to the symbol buffer.
- d_fft_valid  out  1  symbol-buffer write strobe.

Behaviour:
- Reset (async, active-low):
  - all outputs 0; state IDLE; counters 0; buffer contents don't-care.
- States (o_state_OFDM): IDLE=0, PRE=1, FCH=2, LOAD=3, CP=4, BODY=5, DONE=6.
- Output stepping: the output counter advances only in cycles with en=1 and i_wayt_read_data=1, and only in PRE/FCH/CP/BODY.
  - out_data and tx_valid are registered: they are updated in the advancing cycle and visible the next cycle.
  - tx_valid=0 in every other cycle.
- IDLE:
  - beginTX=1 latches data_frame_size and modulation, clears counters, clears done_transmit, enters PRE.
  - beginTX=0 holds in IDLE.
- PRE: emits 160 samples, k=0..159.
  - I = +AMP if k[3]==0, else -AMP; Q = 0.
  - Then FCH.
- FCH: emits 80 samples: CP samples j=48..63, then body j=0..63.
  - Header H = {modulation[2:0], data_frame_size[12:0]} (16 bits).
  - I = +AMP if H[j mod 16]=1, else -AMP; Q = 0.
  - After FCH: LOAD if the latched size is non-zero, else DONE.
- LOAD: flag_ready_read=1.
  - Each cycle with en=1 and valid=1 writes the input sample to buffer address w (0..63).
  - The same cycle drives d_in_fft_data_i/q with that sample and d_fft_valid=1.
  - valid while flag_ready_read=0 is ignored and the data is dropped.
  - After address 63 is written: flag_ready_read=0, enter CP.
- CP: emits buffer[48..63]; then BODY.
- BODY: emits buffer[0..63].
  - Then d_data_symbols_counter increments.
  - If the counter equals the latched size, enter DONE; else LOAD.
- DONE:
  - done_transmit=1 and stays high until the next burst start; flag_ready_read=0.
  - beginTX=1 restarts exactly as from IDLE.
- Burst length: total tx_valid samples = 160 + 80 + 80*N.
- d_counter_sample: index within the current state's sequence; resets to 0 on every state change.
- Changes to data_frame_size or modulation mid-burst have no effect.
- beginTX outside IDLE/DONE is ignored.
- A reset assertion mid-burst aborts immediately to IDLE with all outputs 0.

Test Plan:
- Reset, then beginTX with N=0, modulation=4, ready=1 → exactly 240 tx_valid samples.
  - Sample 0 I=4096; sample 8 I=-4096.
  - done_transmit=1 after the last sample; state 6.
- N=10, modulation=4, input ramp I=k, Q=-k fed on flag_ready_read → 1040 samples.
  - Symbol 0 output after FCH: I = 48..63, then 0..63.
  - d_data_symbols_counter=10 at done.
- FCH check with N=10, modulation=4 (H=0x800A) → FCH body j=1 is +4096, j=0 is -4096, j=15 is +4096.
- Toggle i_wayt_read_data every cycle → tx_valid only on ready cycles.
  - Sample sequence identical to the unstalled run; total still 1040.
- valid held low for 20 cycles mid-LOAD → no output samples, state stays 3.
  - Resumes with no lost or duplicated samples.
- Reset asserted mid-BODY → all outputs 0, state 0.
  - A following beginTX starts a fresh burst from preamble sample 0.
